// File: rtl/seq_det_pkg.sv
// Shared constants for the word-serializing pattern-detector controller:
// FSM encoding and word/counter widths.
package seq_det_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int CNT_W      = $clog2(DEF_WORD_W);
    localparam int MCNT_W     = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/mealy_pat_det.sv
// Bit-serial Mealy detector: flags when the last PAT_LEN bits, oldest first,
// equal PATTERN. Overlapping matches are reported.
module mealy_pat_det #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic det
);

    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    logic [PAT_LEN-1:0] window_s;

    // Candidate window and match decode for the bit currently presented
    always_comb begin
        window_s = {hist_r, bit_in};
        det      = en && (fill_r >= FILL_MAX) && (window_s == PATTERN);
    end

    // History shift and saturating fill count; clr restarts a fresh word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= '0;
            fill_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
            fill_r <= '0;
        end else if (en) begin
            hist_r <= window_s[PAT_LEN-2:0];
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Accepts a word on start, feeds it LSB-first into the Mealy detector and
// records match count and bit positions, pulsing done when the word completes.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 WORD_W  = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    input  logic              abort,
    output logic              ser_bit,
    output logic              det_pulse,
    output logic              busy,
    output logic              done,
    output logic [4:0]        match_count,
    output logic [WORD_W-1:0] match_pos
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    state_t              state_r;
    logic [WORD_W-1:0]   shreg_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [MCNT_W-1:0]   match_count_r;
    logic [WORD_W-1:0]   match_pos_r;
    logic                det_en_s;
    logic                det_clr_s;
    logic                det_s;

    // Detector control and output decode from the state register
    always_comb begin
        det_en_s  = (state_r == ST_SHIFT);
        det_clr_s = (state_r == ST_IDLE) && start;
        ser_bit   = det_en_s ? shreg_r[0] : 1'b0;
        det_pulse = det_s;
        busy      = (state_r == ST_SHIFT);
        done      = (state_r == ST_DONE);
    end

    assign match_count = match_count_r;
    assign match_pos   = match_pos_r;

    mealy_pat_det #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr_s),
        .en     (det_en_s),
        .bit_in (ser_bit),
        .det    (det_s)
    );

    // FSM, serializer and result capture; results persist until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            shreg_r       <= '0;
            cnt_r         <= '0;
            match_count_r <= '0;
            match_pos_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_SHIFT;
                        shreg_r       <= data_in;
                        cnt_r         <= '0;
                        match_count_r <= '0;
                        match_pos_r   <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= {1'b0, shreg_r[WORD_W-1:1]};
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // The bit shown in an abort cycle still counts
                    if (det_s) begin
                        match_count_r      <= match_count_r + 5'd1;
                        match_pos_r[cnt_r] <= 1'b1;
                    end else begin
                        match_count_r <= match_count_r;
                    end
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: vector table, scoreboard of
// expected word results, and hand sequences for abort, held start and reset.
module tb_seq_det_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] data_in;
    logic        ser_bit;
    logic        det_pulse;
    logic        busy;
    logic        done;
    logic [4:0]  match_count;
    logic [15:0] match_pos;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  cnt;
        logic [15:0] pos;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        int          abort_at;
        logic [4:0]  cnt;
        logic [15:0] pos;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    seq_det_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .abort       (abort),
        .ser_bit     (ser_bit),
        .det_pulse   (det_pulse),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .match_pos   (match_pos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: window of four consecutive stream bits, oldest first, equal to 1011
    function automatic exp_t model(input logic [15:0] w, input int last);
        exp_t e;
        logic [3:0] win;
        e.cnt = 5'd0;
        e.pos = 16'h0000;
        for (int i = 3; i < 16; i++) begin
            win = {w[i-3], w[i-2], w[i-1], w[i]};
            if (i <= last && win == 4'b1011) begin
                e.cnt    = e.cnt + 5'd1;
                e.pos[i] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] w, input exp_t e);
        start   = 1'b1;
        data_in = w;
        sb_q.push_back(e);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_count"}, 32'(match_count), 32'(e.cnt));
            check({tag, "_pos"}, 32'(match_pos), 32'(e.pos));
        end
    endtask

    task automatic observe(input logic [15:0] w, input logic [15:0] det_map,
                           input int abort_at, input logic hold);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = hold;
            abort = 1'b0;
            check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
            check($sformatf("ser_bit[%0d]", i), 32'(ser_bit), 32'(w[i]));
            check($sformatf("det_pulse[%0d]", i), 32'(det_pulse), 32'(det_map[i]));
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                compare_result("abort");
                return;
            end
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ser_bit", 32'(ser_bit), 32'd0);
        check("done_det", 32'(det_pulse), 32'd0);
        compare_result("done");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ser_bit"}, 32'(ser_bit), 32'd0);
        check({tag, "_det"}, 32'(det_pulse), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(match_count), 32'd0);
        check({tag, "_pos"}, 32'(match_pos), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [15:0] w;

        vecs[0] = '{data: 16'h5772, abort_at: -1, cnt: 5'd1, pos: 16'h0200};
        vecs[1] = '{data: 16'h006D, abort_at: -1, cnt: 5'd2, pos: 16'h0048};
        vecs[2] = '{data: 16'hFFFF, abort_at: -1, cnt: 5'd0, pos: 16'h0000};
        vecs[3] = '{data: 16'h0000, abort_at: -1, cnt: 5'd0, pos: 16'h0000};
        vecs[4] = '{data: 16'hA000, abort_at: -1, cnt: 5'd0, pos: 16'h0000};
        vecs[5] = '{data: 16'h0001, abort_at: -1, cnt: 5'd0, pos: 16'h0000};
        vecs[6] = '{data: 16'h006D, abort_at: 4,  cnt: 5'd1, pos: 16'h0008};

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = 16'h0000;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            issue(vecs[k].data, '{cnt: vecs[k].cnt, pos: vecs[k].pos});
            observe(vecs[k].data, vecs[k].pos, vecs[k].abort_at, 1'b0);
        end

        // abort while idle is ignored and partial results persist
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_done", 32'(done), 32'd0);
        check("idle_abort_count", 32'(match_count), 32'd1);
        check("idle_abort_pos", 32'(match_pos), 32'h0008);

        // start and abort together in idle: start wins
        @(negedge clk);
        issue(16'h5772, model(16'h5772, 15));
        abort = 1'b1;
        observe(16'h5772, 16'h0200, -1, 1'b0);

        // start held high: ignored in SHIFT and DONE, accepted in following IDLE
        @(negedge clk);
        issue(16'hDB6D, '{cnt: 5'd5, pos: 16'h9248});
        observe(16'hDB6D, 16'h9248, -1, 1'b1);
        sb_q.push_back('{cnt: 5'd5, pos: 16'h9248});
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        observe(16'hDB6D, 16'h9248, -1, 1'b0);

        // asynchronous reset during bit 7 of a word
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'hDB6D;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_count", 32'(match_count), 32'd2);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        check("rst_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(16'h5772, '{cnt: 5'd1, pos: 16'h0200});
        observe(16'h5772, 16'h0200, -1, 1'b0);

        // random words against the reference model
        for (int r = 0; r < 4; r++) begin
            w = 16'($urandom);
            e = model(w, 15);
            @(negedge clk);
            issue(w, e);
            observe(w, e.pos, -1, 1'b0);
        end

        @(negedge clk);
        check("final_idle_busy", 32'(busy), 32'd0);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
